// File: rtl/framebuffer_writer_pkg.sv
// Shared constants, types and FSM encoding for the framebuffer write path.
// Pure declarations; no timing or backpressure of its own.
package fb_pkg;
  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int ADDR_W      = 20;
  localparam int SHADE_W     = 6;
  localparam int MAX_SHADE   = 23;
  localparam int CLEAR_SHADE = 0;

  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [SHADE_W-1:0] shade_t;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } fb_wr_state_t;
endpackage

// File: rtl/framebuffer_writer_if.sv
// Renderer pixel stream (x, y, shade) with valid/ready handshake.
// Transfer happens on a rising edge with valid && ready; no latency inside the interface.
interface fb_pixel_if;
  import fb_pkg::*;

  logic               valid;
  logic               ready;
  logic signed [15:0] x;
  logic signed [15:0] y;
  shade_t             shade;

  modport master (output valid, x, y, shade, input ready);
  modport slave  (input valid, x, y, shade, output ready);
endinterface

// File: rtl/fb_pixel_clip.sv
// Combinational pixel check: on-screen test, linear address, shade clamp to the palette.
// Zero latency, no handshake; results are only meaningful when in_range_o is high.
module fb_pixel_clip #(
  parameter int H_RES     = fb_pkg::H_RES,
  parameter int V_RES     = fb_pkg::V_RES,
  parameter int MAX_SHADE = fb_pkg::MAX_SHADE
) (
  input  logic signed [15:0] x_i,
  input  logic signed [15:0] y_i,
  input  fb_pkg::shade_t     shade_i,
  output logic               in_range_o,
  output fb_pkg::fb_addr_t   addr_o,
  output fb_pkg::shade_t     shade_o
);
  import fb_pkg::*;

  always_comb begin
    in_range_o = (x_i >= 16'sd0) && (int'(x_i) < H_RES) &&
                 (y_i >= 16'sd0) && (int'(y_i) < V_RES);
    // Off-screen coordinates give a garbage address, but nothing uses it then.
    addr_o  = fb_addr_t'(32'(H_RES) * 32'(y_i) + 32'(x_i));
    shade_o = (shade_i > shade_t'(MAX_SHADE)) ? shade_t'(MAX_SHADE) : shade_i;
  end
endmodule

// File: rtl/framebuffer_writer.sv
// Drives frame BRAM port A from the pixel stream (1-cycle latency, 1 pixel/cycle) or a full clear sweep.
// s_ready drops while clearing or when a clear is requested; the BRAM never stalls.
module framebuffer_writer #(
  parameter int H_RES       = fb_pkg::H_RES,
  parameter int V_RES       = fb_pkg::V_RES,
  parameter int MAX_SHADE   = fb_pkg::MAX_SHADE,
  parameter int CLEAR_SHADE = fb_pkg::CLEAR_SHADE
) (
  input  logic             clk,
  input  logic             rst_n,
  fb_pixel_if.slave        pix,
  input  logic             clear_start,
  output logic             busy,
  output logic             clear_done,
  output logic [15:0]      drop_count,
  output logic             en_write_framebuffer,
  output fb_pkg::fb_addr_t framebuffer_addr,
  output fb_pkg::shade_t   framebuffer_data
);
  import fb_pkg::*;

  localparam int       TOTAL     = H_RES * V_RES;
  localparam fb_addr_t LAST_ADDR = fb_addr_t'(TOTAL - 1);

  fb_wr_state_t state_q, state_d;
  fb_addr_t     cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [15:0]  drop_q, drop_d;
  logic         en_q, en_d;
  fb_addr_t     addr_q, addr_d;
  shade_t       data_q, data_d;

  logic     accept;
  logic     pix_in_range;
  fb_addr_t pix_addr;
  shade_t   pix_shade;

  // A clear request wins over a pixel offered in the same cycle.
  assign pix.ready = (state_q == RUN) && !clear_start;
  assign accept    = pix.valid && pix.ready;

  fb_pixel_clip #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .MAX_SHADE (MAX_SHADE)
  ) u_clip (
    .x_i        (pix.x),
    .y_i        (pix.y),
    .shade_i    (pix.shade),
    .in_range_o (pix_in_range),
    .addr_o     (pix_addr),
    .shade_o    (pix_shade)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      RUN: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (accept) begin
          if (pix_in_range) begin
            en_d   = 1'b1;
            addr_d = pix_addr;
            data_d = pix_shade;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      CLEAR: begin
        en_d   = 1'b1;
        addr_d = cnt_q;
        data_d = shade_t'(CLEAR_SHADE);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Busy stays up through the final strobe so it frames every clear write.
    busy_d = (state_d == CLEAR) || done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy                 = busy_q;
  assign clear_done           = done_q;
  assign drop_count           = drop_q;
  assign en_write_framebuffer = en_q;
  assign framebuffer_addr     = addr_q;
  assign framebuffer_data     = data_q;
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed and randomized checks of framebuffer_writer: a full-size instance for addressing,
// and an 8x4 instance for clear sweeps and random traffic against a simple arithmetic model.
module tb_framebuffer_writer;
  import fb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fb_pixel_if ifb ();
  fb_pixel_if ifs ();

  logic        cs_b, busy_b, done_b, en_b;
  logic [15:0] drop_b;
  fb_addr_t    addr_b;
  shade_t      data_b;

  logic        cs_s, busy_s, done_s, en_s;
  logic [15:0] drop_s;
  fb_addr_t    addr_s;
  shade_t      data_s;

  framebuffer_writer u_big (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pix                  (ifb),
    .clear_start          (cs_b),
    .busy                 (busy_b),
    .clear_done           (done_b),
    .drop_count           (drop_b),
    .en_write_framebuffer (en_b),
    .framebuffer_addr     (addr_b),
    .framebuffer_data     (data_b)
  );

  framebuffer_writer #(.H_RES(8), .V_RES(4), .MAX_SHADE(23), .CLEAR_SHADE(0)) u_small (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pix                  (ifs),
    .clear_start          (cs_s),
    .busy                 (busy_s),
    .clear_done           (done_s),
    .drop_count           (drop_s),
    .en_write_framebuffer (en_s),
    .framebuffer_addr     (addr_s),
    .framebuffer_data     (data_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input int x, input int y, input int sh);
    ifb.valid = v;
    ifb.x     = 16'(x);
    ifb.y     = 16'(y);
    ifb.shade = shade_t'(sh);
  endtask

  task automatic drive_s(input logic v, input int x, input int y, input int sh);
    ifs.valid = v;
    ifs.x     = 16'(x);
    ifs.y     = 16'(y);
    ifs.shade = shade_t'(sh);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cx[4];
    int cy[4];
    int n;
    int exp_drop;
    logic exp_vld;
    int exp_addr, exp_data;
    int v, x, y, sh;

    cx = '{-1, 640, 0, 5};
    cy = '{5, 0, 480, -3};

    drive_b(1'b0, 0, 0, 0);
    drive_s(1'b0, 0, 0, 0);
    cs_b  = 1'b0;
    cs_s  = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_en",    en_b,   0);
    chk("rst_addr",  addr_b, 0);
    chk("rst_data",  data_b, 0);
    chk("rst_busy",  busy_b, 0);
    chk("rst_done",  done_b, 0);
    chk("rst_drop",  drop_b, 0);
    chk("rst_ready", ifb.ready, 1);
    chk("rst_busy_s", busy_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;

    // Basic write on the 640x480 instance
    drive_b(1'b1, 3, 2, 10);
    #1 chk("basic_ready", ifb.ready, 1);
    tick;
    chk("basic_en",   en_b,   1);
    chk("basic_addr", addr_b, 1283);
    chk("basic_data", data_b, 10);
    drive_b(1'b0, 0, 0, 0);
    tick;
    chk("basic_idle_en",   en_b,   0);
    chk("basic_hold_addr", addr_b, 1283);

    // Corners and shade saturation, back-to-back
    drive_b(1'b1, 639, 479, 40);
    tick;
    chk("corner_en",   en_b,   1);
    chk("corner_addr", addr_b, 307199);
    chk("corner_data", data_b, 23);
    drive_b(1'b1, 0, 0, 23);
    tick;
    chk("origin_en",   en_b,   1);
    chk("origin_addr", addr_b, 0);
    chk("origin_data", data_b, 23);

    // Off-screen pixels are accepted and counted, never written
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, cx[i], cy[i], 9);
      #1 chk("clip_ready", ifb.ready, 1);
      tick;
      chk("clip_no_write", en_b, 0);
    end
    drive_b(1'b0, 0, 0, 0);
    chk("clip_drop", drop_b, 4);

    // Clear sweep on 8x4 with a pixel held against the clear request
    drive_s(1'b1, 5, 2, 7);
    cs_s = 1'b1;
    #1 chk("clr_req_ready", ifs.ready, 0);
    tick;
    cs_s = 1'b0;
    chk("clr_busy0", busy_s, 1);
    chk("clr_en0",   en_s,   0);
    #1 chk("clr_ready0", ifs.ready, 0);
    for (int k = 0; k < 32; k++) begin
      tick;
      chk("sweep_en",    en_s,   1);
      chk("sweep_addr",  addr_s, k);
      chk("sweep_data",  data_s, 0);
      chk("sweep_done",  done_s, (k == 31));
      chk("sweep_busy",  busy_s, 1);
      chk("sweep_ready", ifs.ready, (k == 31));
      cs_s = (k == 9);
    end
    cs_s = 1'b0;
    tick;
    chk("held_en",   en_s,   1);
    chk("held_addr", addr_s, 21);
    chk("held_data", data_s, 7);
    chk("held_busy", busy_s, 0);
    chk("held_done", done_s, 0);
    drive_s(1'b0, 0, 0, 0);
    tick;
    chk("post_idle_en", en_s, 0);

    // Reset in the middle of a sweep
    cs_s = 1'b1;
    tick;
    cs_s = 1'b0;
    n = 0;
    do begin
      tick;
      n++;
    end while (!(en_s && addr_s == 10) && n < 40);
    chk("midrst_reach", (en_s && addr_s == 10), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_en",   en_s,   0);
    chk("midrst_addr", addr_s, 0);
    chk("midrst_data", data_s, 0);
    chk("midrst_busy", busy_s, 0);
    chk("midrst_done", done_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("after_rst_busy",  busy_s,    0);
    chk("after_rst_ready", ifs.ready, 1);
    drive_s(1'b1, 1, 1, 5);
    tick;
    chk("after_rst_en",   en_s,   1);
    chk("after_rst_addr", addr_s, 9);
    chk("after_rst_data", data_s, 5);

    // Random traffic against an arithmetic reference of the 8x4 screen
    exp_drop = 0;
    for (int i = 0; i < 300; i++) begin
      v  = int'($urandom_range(0, 1));
      x  = int'($urandom_range(0, 13)) - 3;
      y  = int'($urandom_range(0, 8)) - 2;
      sh = int'($urandom_range(0, 63));
      drive_s(v[0], x, y, sh);
      #1 chk("rnd_ready", ifs.ready, 1);
      exp_vld = 1'b0;
      if (v == 1) begin
        if (x >= 0 && x < 8 && y >= 0 && y < 4) begin
          exp_vld  = 1'b1;
          exp_addr = y * 8 + x;
          exp_data = (sh > 23) ? 23 : sh;
        end else begin
          exp_drop++;
        end
      end
      tick;
      chk("rnd_en", en_s, exp_vld);
      if (exp_vld) begin
        chk("rnd_addr", addr_s, exp_addr);
        chk("rnd_data", data_s, exp_data);
      end
    end
    drive_s(1'b0, 0, 0, 0);
    tick;
    chk("rnd_drop", drop_s, exp_drop);
    chk("rnd_tail_en", en_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
